// File: rtl/majority_vote_controller.sv
// Three-voter majority controller: collects one vote per voter per round and reports the majority, dissenters and unanimity.
// Optional round timeout is compiled in with `define VOTE_TIMEOUT_EN.
module majority_vote_controller #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       a_vld,
    input  logic       b_vld,
    input  logic       c_vld,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       y,
    output logic       unanimous,
    output logic [2:0] dissent,
    output logic       timeout
);

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be in 2..255");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t     state;
    logic [2:0] flag;
    logic [2:0] vote;

    logic [2:0] vld_in;
    logic [2:0] bit_in;
    logic [2:0] cap;
    logic [2:0] have;
    logic [2:0] val;
    logic [2:0] disagree;
    logic       all_in;
    logic       maj;
    logic       close_round;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    assign vld_in = {c_vld, b_vld, a_vld};
    assign bit_in = {c, b, a};

    // Merge already-held votes with this edge's first-time captures; missing voters read as 0.
    assign cap      = vld_in & ~flag;
    assign have     = flag | cap;
    assign val      = (flag & vote) | (cap & bit_in);
    assign all_in   = &have;
    assign maj      = majority3(val);
    assign disagree = val ^ {3{maj}};

    assign busy = (state != IDLE);

`ifdef VOTE_TIMEOUT_EN
    logic [7:0] cnt;
    logic       expire;

    // Expiry is the edge on which the COLLECT edge count reaches TIMEOUT_CYCLES.
    assign expire      = (cnt == 8'(TIMEOUT_CYCLES - 1));
    assign close_round = all_in | expire;
`else
    assign close_round = all_in;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flag      <= 3'b000;
            vote      <= 3'b000;
            done      <= 1'b0;
            y         <= 1'b0;
            unanimous <= 1'b0;
            dissent   <= 3'b000;
`ifdef VOTE_TIMEOUT_EN
            timeout   <= 1'b0;
            cnt       <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= COLLECT;
                        flag      <= 3'b000;
                        vote      <= 3'b000;
                        y         <= 1'b0;
                        unanimous <= 1'b0;
                        dissent   <= 3'b000;
`ifdef VOTE_TIMEOUT_EN
                        timeout   <= 1'b0;
                        cnt       <= 8'd0;
`endif
                    end
                end
                COLLECT: begin
                    flag <= have;
                    vote <= val;
`ifdef VOTE_TIMEOUT_EN
                    cnt  <= cnt + 8'd1;
`endif
                    if (close_round) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        y         <= maj;
                        dissent   <= ~have | disagree;
                        unanimous <= all_in & ~|disagree;
`ifdef VOTE_TIMEOUT_EN
                        // A vote completing on the expiry edge wins over the timeout.
                        timeout   <= ~all_in;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_majority_vote_controller.sv
// Bench for majority_vote_controller: directed and random vote rounds against an event-list reference model.
module tb_majority_vote_controller;

    localparam int TO   = 16;
    localparam int MAXC = 48;
`ifdef VOTE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       a_vld, b_vld, c_vld;
    logic       a, b, c;
    logic       busy, done, y, unanimous, timeout;
    logic [2:0] dissent;

    int errors = 0;
    int checks = 0;

    bit [2:0] ev_v [0:MAXC];
    bit [2:0] ev_b [0:MAXC];

    int       exp_close;
    bit       exp_y, exp_un, exp_to;
    bit [2:0] exp_dis;

    majority_vote_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_vld(a_vld), .b_vld(b_vld), .c_vld(c_vld),
        .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .y(y), .unanimous(unanimous),
        .dissent(dissent), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each voter's vote is its first valid after start; the round closes at the
    // latest first-vote cycle, or at TO when that is later (timeout build only).
    function automatic void model();
        int       first [3];
        int       last;
        int       lim;
        int       ones;
        bit [2:0] capd;
        bit [2:0] vals;
        last = 0;
        for (int i = 0; i < 3; i++) begin
            first[i] = MAXC + 1;
            vals[i]  = 1'b0;
            for (int k = 1; k <= MAXC; k++) begin
                if (ev_v[k][i] && first[i] > MAXC) begin
                    first[i] = k;
                    vals[i]  = ev_b[k][i];
                end
            end
            if (first[i] > last) last = first[i];
        end
        lim = TO_EN ? TO : MAXC;
        if (last <= lim) begin
            exp_close = last;
            exp_to    = 1'b0;
        end else begin
            exp_close = TO;
            exp_to    = 1'b1;
        end
        ones = 0;
        for (int i = 0; i < 3; i++) begin
            capd[i] = (first[i] <= exp_close);
            if (capd[i] && vals[i]) ones++;
        end
        exp_y = (ones >= 2);
        for (int i = 0; i < 3; i++)
            exp_dis[i] = !capd[i] || (vals[i] != exp_y);
        exp_un = (capd == 3'b111) && (exp_dis == 3'b000);
    endfunction

    task automatic clear_events();
        for (int k = 0; k <= MAXC; k++) begin
            ev_v[k] = 3'b000;
            ev_b[k] = 3'b000;
        end
    endtask

    task automatic drive_votes(input bit [2:0] v, input bit [2:0] bv);
        {c_vld, b_vld, a_vld} = v;
        {c, b, a}             = bv;
    endtask

    task automatic run_round(input string name);
        model();
        start = 1'b1;
        drive_votes(ev_v[0], ev_b[0]);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || y !== 1'b0 || unanimous !== 1'b0 ||
            dissent !== 3'b000 || timeout !== 1'b0)
            begin errors++; $display("FAIL %s start_clear: busy=%b done=%b y=%b un=%b dis=%b to=%b, want 1 0 0 0 000 0",
                name, busy, done, y, unanimous, dissent, timeout); end
        for (int k = 1; k <= exp_close; k++) begin
            start = 1'($urandom_range(0, 1));
            drive_votes(ev_v[k], ev_b[k]);
            @(posedge clk); #1;
            if (k < exp_close) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b1)
                    begin errors++; $display("FAIL %s collect_k%0d: done=%b busy=%b, want 0 1", name, k, done, busy); end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL %s done_pulse: done=%b busy=%b, want 1 1", name, done, busy); end
        checks++;
        if (y !== exp_y) begin errors++; $display("FAIL %s y: got %b want %b", name, y, exp_y); end
        checks++;
        if (dissent !== exp_dis) begin errors++; $display("FAIL %s dissent: got %b want %b", name, dissent, exp_dis); end
        checks++;
        if (unanimous !== exp_un) begin errors++; $display("FAIL %s unanimous: got %b want %b", name, unanimous, exp_un); end
        checks++;
        if (timeout !== exp_to) begin errors++; $display("FAIL %s timeout: got %b want %b", name, timeout, exp_to); end
        // start during DONE must be ignored; results hold through the following idle cycle
        start = 1'b1;
        drive_votes(3'($urandom), 3'($urandom));
        @(posedge clk); #1;
        start = 1'b0;
        drive_votes(3'($urandom), 3'($urandom));
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== exp_y || dissent !== exp_dis ||
            unanimous !== exp_un || timeout !== exp_to)
            begin errors++; $display("FAIL %s hold1: busy=%b done=%b y=%b dis=%b un=%b to=%b", name, busy, done, y, dissent, unanimous, timeout); end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== exp_y || dissent !== exp_dis ||
            unanimous !== exp_un || timeout !== exp_to)
            begin errors++; $display("FAIL %s hold2: busy=%b done=%b y=%b dis=%b un=%b to=%b", name, busy, done, y, dissent, unanimous, timeout); end
        drive_votes(3'b000, 3'b000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        drive_votes(3'b000, 3'b000);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 1'b0 || unanimous !== 1'b0 ||
            dissent !== 3'b000 || timeout !== 1'b0)
            begin errors++; $display("FAIL reset_state: busy=%b done=%b y=%b un=%b dis=%b to=%b", busy, done, y, unanimous, dissent, timeout); end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done); end
    endtask

    task automatic test_basic();
        clear_events();
        ev_v[0] = 3'b111; ev_b[0] = 3'b111;
        ev_v[1] = 3'b111; ev_b[1] = 3'b010;
        run_round("basic");
    endtask

    task automatic test_staggered();
        clear_events();
        ev_v[1] = 3'b001; ev_b[1] = 3'b001;
        ev_v[2] = 3'b001; ev_b[2] = 3'b000;
        ev_v[3] = 3'b100; ev_b[3] = 3'b100;
        ev_v[5] = 3'b010; ev_b[5] = 3'b000;
        run_round("staggered");
    endtask

    task automatic test_unanimous();
        clear_events();
        ev_v[1] = 3'b111; ev_b[1] = 3'b111;
        run_round("unanimous");
    endtask

    task automatic test_timeout();
        clear_events();
        ev_v[1] = 3'b001; ev_b[1] = 3'b001;
        ev_v[30] = 3'b110; ev_b[30] = 3'b110;
        run_round("timeout");
    endtask

    task automatic test_last_at_expiry();
        clear_events();
        ev_v[1]  = 3'b001; ev_b[1]  = 3'b000;
        ev_v[5]  = 3'b010; ev_b[5]  = 3'b010;
        ev_v[TO] = 3'b100; ev_b[TO] = 3'b100;
        run_round("last_at_expiry");
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive_votes(3'b001, 3'b001);
        @(posedge clk); #1;
        drive_votes(3'b000, 3'b000);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 1'b0 || dissent !== 3'b000)
            begin errors++; $display("FAIL reset_mid_async: busy=%b done=%b y=%b dis=%b, want 0 0 0 000", busy, done, y, dissent); end
        @(posedge clk); #2;
        rst = 1'b0;
        drive_votes(3'b111, 3'b111);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL reset_mid_after: busy=%b done=%b, want 0 0", busy, done); end
        drive_votes(3'b000, 3'b000);
        clear_events();
        ev_v[1] = 3'b101; ev_b[1] = 3'b100;
        ev_v[2] = 3'b010; ev_b[2] = 3'b000;
        run_round("after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            clear_events();
            ev_v[0] = 3'($urandom);
            ev_b[0] = 3'($urandom);
            for (int k = 1; k <= 24; k++) begin
                for (int i = 0; i < 3; i++)
                    ev_v[k][i] = ($urandom_range(0, 5) == 0);
                ev_b[k] = 3'($urandom);
            end
            for (int i = 0; i < 3; i++) begin
                if (TO_EN && $urandom_range(0, 4) == 0) begin
                    for (int k = 1; k <= 24; k++) ev_v[k][i] = 1'b0;
                end else if (!TO_EN) begin
                    ev_v[24][i] = 1'b1;
                end
            end
            run_round($sformatf("random%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_staggered();
        test_unanimous();
        test_timeout();
        test_last_at_expiry();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/majority_vote_controller.md
MAJORITY_VOTE_CONTROLLER -- requirements
Module: majority_vote_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, legal 2..255: maximum COLLECT cycles before forced decision.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin a vote round; sampled only in IDLE.
REQ-005 SHALL have ports a_vld, b_vld, c_vld  input  1 each  vote-present strobes from voters a, b and c.
REQ-006 SHALL have ports a, b, c  input  1 each  vote bit, qualified by matching _vld.
REQ-007 SHALL have port busy  output  1  high while state is COLLECT or DONE.
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port y  output  1  majority decision.
REQ-010 SHALL have port unanimous  output  1  all three votes captured and equal.
REQ-011 SHALL have port dissent  output  3  bit0=a, bit1=b, bit2=c; voter missing or disagreeing with y.
REQ-012 SHALL have port timeout  output  1  round closed by timeout with at least one vote missing.

Function
REQ-013 SHALL implement FSM states IDLE, COLLECT, DONE; encoding is free.
REQ-014 IDLE: start=1 at an edge -> COLLECT; capture flags and cycle counter cleared at that edge; votes presented in the same cycle as start are ignored.
REQ-015 COLLECT: voter x captured at the first edge where x_vld=1 and its flag is clear; later x_vld for that voter ignored in the round.
REQ-016 Simultaneous valids from two or three voters SHALL all be captured at the same edge.
REQ-017 When the third vote is captured (flags plus current-edge captures), FSM -> DONE at that edge; result registers load at the same edge.
REQ-018 With timeout compiled in, counter counts COLLECT edges; at the edge where the count reaches TIMEOUT_CYCLES without all three votes, FSM -> DONE with timeout=1.
REQ-019 If the final vote arrives at the expiry edge, completion wins: timeout=0.
REQ-020 Missing votes SHALL count as 0; y = (va&vb)|(va&vc)|(vb&vc) over captured values.
REQ-021 dissent[i] = voter i missing, or captured value != y; unanimous = all captured and dissent=3'b000.
REQ-022 DONE lasts exactly one cycle with done=1, then -> IDLE; start during DONE is ignored.
REQ-023 y, unanimous, dissent, timeout SHALL hold from DONE until the edge where the next start is accepted, then clear to 0.
REQ-024 Minimum latency: start accepted at edge 0, all votes at edge 1, done high in cycle after edge 1 (2 edges start-to-done).
REQ-025 busy SHALL be combinational from state; all other outputs registered.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, busy=0, done=0, y=0, unanimous=0, dissent=3'b000, timeout=0, flags and counter cleared.
REQ-027 Reset mid-COLLECT SHALL abort the round with no done pulse; first edge after release is evaluated from IDLE.

Configuration
REQ-028 Macro VOTE_TIMEOUT_EN: when defined, counter and REQ-018/019 are included.
REQ-029 Without VOTE_TIMEOUT_EN, COLLECT waits indefinitely for all three votes, timeout output tied 0, no counter logic present.

Verification
REQ-030 start; next cycle a=0,b=1,c=0 all valid -> done after 2 edges, y=0, unanimous=0, dissent=3'b010.
REQ-031 start; votes a=1 (cycle 1), c=1 (cycle 3), b=0 (cycle 5) -> y=1, dissent=3'b010, timeout=0; duplicate a_vld with a=0 at cycle 2 has no effect.
REQ-032 start; a=1,b=1,c=1 simultaneous -> y=1, unanimous=1, dissent=3'b000.
REQ-033 VOTE_TIMEOUT_EN, TIMEOUT_CYCLES=16: start; only a=1 -> done after 16 COLLECT edges, timeout=1, y=0, dissent=3'b111.
REQ-034 rst pulsed in COLLECT after one vote -> busy=0 immediately, no done; new start with a=0,b=0,c=1 -> y=0, dissent=3'b100.
REQ-035 start asserted in COLLECT and DONE -> ignored; results hold unchanged until next start in IDLE.
